ram_datos_bytes: RTL and testbench

- Byte-addressable MIPS data memory, successor to the word-only data RAM in the TP4 pipeline MEM stage.
- Port A serves the MEM stage with byte, halfword and word loads and stores, per-lane write enables, sign or zero extension, and misalignment detection.
- Port B is an internal dump engine that streams a configurable range of words to the debug unit over a valid/ready handshake, without stalling port A.

---
 rtl/ram_datos_bytes.sv | 182 ++++++++++++++++++
 tb/tb_ram_datos_bytes.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_datos_bytes.sv
// Byte-addressable MIPS data RAM: port A serves byte/half/word loads and stores, port B dumps words to the debug unit.
// Defining RAM_DATOS_OUTREG_EN adds one falling-edge output register to douta/misalign (load latency 2).
module ram_datos_bytes #(
    parameter int    RAM_DEPTH  = 1024,
    parameter int    RAM_WIDTH  = 32,
    parameter string INIT_FILE  = "",
    parameter int    DUMP_WORDS = RAM_DEPTH,
    parameter int    ADDR_W     = $clog2(RAM_DEPTH) + 2,
    parameter int    WADDR_W    = $clog2(RAM_DEPTH)
) (
    input  logic               clka,
    input  logic               rsta,
    input  logic               ena,
    input  logic               wea,
    input  logic [ADDR_W-1:0]  addra,
    input  logic [1:0]         size,
    input  logic               unsigned_ld,
    input  logic [31:0]        dina,
    output logic [31:0]        douta,
    output logic               misalign,
    input  logic               dump_start,
    input  logic               dump_ready,
    output logic               dump_valid,
    output logic [31:0]        dump_data,
    output logic [WADDR_W-1:0] dump_addr,
    output logic               dump_last,
    output logic               dump_busy
);

    if (RAM_WIDTH != 32) begin : g_bad_width
        $error("ram_datos_bytes: RAM_WIDTH must be 32");
    end
    if ((RAM_DEPTH < 2) || ((RAM_DEPTH & (RAM_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("ram_datos_bytes: RAM_DEPTH must be a power of 2");
    end
    if ((DUMP_WORDS < 1) || (DUMP_WORDS > RAM_DEPTH)) begin : g_bad_dump
        $error("ram_datos_bytes: DUMP_WORDS must be in 1..RAM_DEPTH");
    end

    typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_BAD = 2'b11} size_e;
    typedef enum logic [1:0] {IDLE, FETCH, SHOW} dump_state_e;

    localparam logic [WADDR_W-1:0] LAST_PTR = WADDR_W'(DUMP_WORDS - 1);

    logic [31:0]        mem [RAM_DEPTH];
    logic [WADDR_W-1:0] word_idx;
    logic [1:0]         offset;
    size_e              sz;
    logic               legal;
    logic [3:0]         lane_we;
    logic [31:0]        wdata;
    logic [31:0]        rd_word;
    logic [7:0]         rd_byte;
    logic [15:0]        rd_half;
    logic [31:0]        load_val;
    logic [31:0]        a_data;
    logic               a_err;
    dump_state_e        state;
    logic [WADDR_W-1:0] ptr;

    // Power-up image of the array: zero-initialised contents.
    initial begin
        for (int i = 0; i < RAM_DEPTH; i++) mem[i] = '0;
    end

    assign word_idx = addra[ADDR_W-1:2];
    assign offset   = addra[1:0];
    assign sz       = size_e'(size);

    always_comb begin
        legal   = 1'b0;
        lane_we = 4'b0000;
        wdata   = dina;
        unique case (sz)
            SZ_BYTE: begin
                legal   = 1'b1;
                lane_we = 4'b0001 << offset;
                wdata   = {4{dina[7:0]}};
            end
            SZ_HALF: begin
                legal   = ~offset[0];
                lane_we = offset[1] ? 4'b1100 : 4'b0011;
                wdata   = {2{dina[15:0]}};
            end
            SZ_WORD: begin
                legal   = (offset == 2'b00);
                lane_we = 4'b1111;
            end
            default: ;
        endcase
        if (!(ena && wea && legal)) lane_we = 4'b0000;
    end

    // NOTE: the array is never reset; rsta only clears the control/output registers, so contents survive it.
    always_ff @(negedge clka) begin
        for (int k = 0; k < 4; k++) begin
            if (lane_we[k]) mem[word_idx][8*k +: 8] <= wdata[8*k +: 8];
        end
    end

    always_comb begin
        rd_word  = mem[word_idx];
        rd_byte  = rd_word[8*offset +: 8];
        rd_half  = offset[1] ? rd_word[31:16] : rd_word[15:0];
        unique case (sz)
            SZ_BYTE: load_val = {{24{~unsigned_ld & rd_byte[7]}}, rd_byte};
            SZ_HALF: load_val = {{16{~unsigned_ld & rd_half[15]}}, rd_half};
            default: load_val = rd_word;
        endcase
    end

    // Stores leave douta untouched (no-change mode); illegal accesses only raise the error flag.
    always_ff @(negedge clka or posedge rsta) begin
        if (rsta) begin
            a_data <= '0;
            a_err  <= 1'b0;
        end else if (ena) begin
            a_err <= ~legal;
            if (legal && !wea) a_data <= load_val;
        end
    end

`ifdef RAM_DATOS_OUTREG_EN
    always_ff @(negedge clka or posedge rsta) begin
        if (rsta) begin
            douta    <= '0;
            misalign <= 1'b0;
        end else begin
            douta    <= a_data;
            misalign <= a_err;
        end
    end
`else
    assign douta    = a_data;
    assign misalign = a_err;
`endif

    // FETCH samples mem before any same-edge port A store lands, so the dump sees the old word.
    always_ff @(negedge clka or posedge rsta) begin
        if (rsta) begin
            state      <= IDLE;
            ptr        <= '0;
            dump_valid <= 1'b0;
            dump_data  <= '0;
            dump_addr  <= '0;
            dump_last  <= 1'b0;
            dump_busy  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (dump_start) begin
                        ptr       <= '0;
                        dump_busy <= 1'b1;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    dump_data  <= mem[ptr];
                    dump_addr  <= ptr;
                    dump_last  <= (ptr == LAST_PTR);
                    dump_valid <= 1'b1;
                    state      <= SHOW;
                end
                SHOW: begin
                    if (dump_ready) begin
                        dump_valid <= 1'b0;
                        if (dump_last) begin
                            dump_last <= 1'b0;
                            dump_busy <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            ptr   <= ptr + 1'b1;
                            state <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_datos_bytes.sv
// Scoreboard bench for ram_datos_bytes: byte-array reference model, port A and dump queues checked by a monitor.
module tb_ram_datos_bytes;

    localparam int DEPTH = 16;
    localparam int DW    = 4;
    localparam int AW    = $clog2(DEPTH) + 2;
    localparam int WAW   = $clog2(DEPTH);
`ifdef RAM_DATOS_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic           clka = 1'b0;
    logic           rsta, ena, wea, unsigned_ld, dump_start, dump_ready;
    logic [AW-1:0]  addra;
    logic [1:0]     size;
    logic [31:0]    dina, douta, dump_data;
    logic           misalign, dump_valid, dump_last, dump_busy;
    logic [WAW-1:0] dump_addr;

    ram_datos_bytes #(.RAM_DEPTH(DEPTH), .DUMP_WORDS(DW)) dut (
        .clka(clka), .rsta(rsta), .ena(ena), .wea(wea), .addra(addra), .size(size),
        .unsigned_ld(unsigned_ld), .dina(dina), .douta(douta), .misalign(misalign),
        .dump_start(dump_start), .dump_ready(dump_ready), .dump_valid(dump_valid),
        .dump_data(dump_data), .dump_addr(dump_addr), .dump_last(dump_last), .dump_busy(dump_busy)
    );

    always #5 clka = ~clka;

    typedef struct { int due; logic [31:0] data; logic err; } a_exp_t;
    typedef struct { logic [WAW-1:0] addr; logic [31:0] data; logic last; } d_exp_t;

    a_exp_t       aq[$];
    d_exp_t       dq[$];
    byte unsigned mem_m [DEPTH*4];
    logic [31:0]  m_douta = '0;
    logic         m_err = 1'b0;
    bit           m_busy = 1'b0;
    bit           in_reset = 1'b1;
    int           edges = 0;
    int           vectors = 0;
    int           miscompares = 0;

    always @(negedge clka) edges <= edges + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: flat little-endian byte array, access width = 1 << size.
    function automatic bit legal_m(input int a, input int s);
        return (s != 3) && ((a % (1 << s)) == 0);
    endfunction

    function automatic logic [31:0] load_m(input int a, input int s, input bit uns);
        int     n;
        longint v;
        n = 1 << s;
        v = 0;
        for (int i = 0; i < n; i++) v = v | (longint'(mem_m[a+i]) << (8*i));
        if (!uns && n < 4 && v >= (longint'(1) << (8*n - 1))) v = v - (longint'(1) << (8*n));
        return v[31:0];
    endfunction

    function automatic void store_m(input int a, input int s, input logic [31:0] d);
        for (int i = 0; i < (1 << s); i++) mem_m[a+i] = 8'(d >> (8*i));
    endfunction

    task automatic cycle(input bit e, input bit w, input int a, input int s, input bit u,
                         input logic [31:0] d, input bit st, input bit rdy);
        @(posedge clka);
        ena = e; wea = w; addra = a[AW-1:0]; size = s[1:0]; unsigned_ld = u; dina = d;
        dump_start = st; dump_ready = rdy;
        if (e) begin
            if (!legal_m(a, s)) m_err = 1'b1;
            else begin
                m_err = 1'b0;
                if (w) store_m(a, s, d);
                else   m_douta = load_m(a, s, u);
            end
        end
        if (st && !m_busy) begin
            m_busy = 1'b1;
            for (int i = 0; i < DW; i++)
                dq.push_back('{addr: WAW'(i), data: load_m(4*i, 2, 1'b0), last: (i == DW-1)});
        end
        aq.push_back('{due: edges + LAT, data: m_douta, err: m_err});
    endtask

    task automatic idle(input bit rdy);
        cycle(1'b0, 1'b0, 0, 0, 1'b0, 32'h0, 1'b0, rdy);
    endtask

    task automatic expect_a(input string name, input logic [31:0] d, input logic e);
        repeat (LAT) idle(1'b1);
        #2;
        check(name, douta, d);
        check({name, "_misalign"}, {31'b0, misalign}, {31'b0, e});
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_douta"}, douta, 32'h0);
        check({name, "_misalign"}, {31'b0, misalign}, 32'h0);
        check({name, "_dump_valid"}, {31'b0, dump_valid}, 32'h0);
        check({name, "_dump_data"}, dump_data, 32'h0);
        check({name, "_dump_addr"}, 32'(dump_addr), 32'h0);
        check({name, "_dump_last"}, {31'b0, dump_last}, 32'h0);
        check({name, "_dump_busy"}, {31'b0, dump_busy}, 32'h0);
    endtask

    task automatic drain_dump(input string name, input int budget);
        int n;
        for (n = 0; n < budget; n++) begin
            idle(1'b1);
            #2;
            if (dq.size() == 0 && !dump_busy) break;
        end
        check({name, "_queue_drained"}, dq.size(), 0);
        check({name, "_busy_clear"}, {31'b0, dump_busy}, 32'h0);
    endtask

    // Monitor: port A expectations pop on their due edge; dump words are compared whenever dump_valid is up.
    initial begin
        a_exp_t x;
        forever begin
            @(posedge clka);
            #2;
            if (in_reset) continue;
            while (aq.size() > 0 && aq[0].due <= edges) begin
                x = aq.pop_front();
                check("douta", douta, x.data);
                check("misalign", {31'b0, misalign}, {31'b0, x.err});
            end
            if (dump_valid) begin
                check("dump_busy_with_valid", {31'b0, dump_busy}, 32'h1);
                if (dq.size() == 0) check("dump_unexpected_valid", {31'b0, dump_valid}, 32'h0);
                else begin
                    check("dump_addr", 32'(dump_addr), 32'(dq[0].addr));
                    check("dump_data", dump_data, dq[0].data);
                    check("dump_last", {31'b0, dump_last}, {31'b0, dq[0].last});
                    if (dump_ready) begin
                        if (dq[0].last) m_busy = 1'b0;
                        void'(dq.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int  a, s, iters;
        bit  w, found;
        rsta = 1'b1; ena = 1'b0; wea = 1'b0; addra = '0; size = 2'b00; unsigned_ld = 1'b0;
        dina = '0; dump_start = 1'b0; dump_ready = 1'b0;
        repeat (3) @(posedge clka);
        #1;
        check_all_zero("reset");
        rsta = 1'b0;
        in_reset = 1'b0;

        // 1: word store / word load
        cycle(1, 1, 'h10, 2, 0, 32'h8899AABB, 0, 1);
        cycle(1, 0, 'h10, 2, 0, 32'h0, 0, 1);
        expect_a("t1_word_load", 32'h8899AABB, 1'b0);

        // 2: byte store, signed/unsigned byte loads, word readback
        cycle(1, 1, 'h12, 0, 0, 32'h000000F0, 0, 1);
        cycle(1, 0, 'h12, 0, 0, 32'h0, 0, 1);
        expect_a("t2_byte_signed", 32'hFFFFFFF0, 1'b0);
        cycle(1, 0, 'h12, 0, 1, 32'h0, 0, 1);
        expect_a("t2_byte_unsigned", 32'h000000F0, 1'b0);
        cycle(1, 0, 'h10, 2, 0, 32'h0, 0, 1);
        expect_a("t2_word_merged", 32'h88F0AABB, 1'b0);

        // 3: misaligned half load and word store, then a legal access clears the flag
        cycle(1, 0, 'h11, 1, 0, 32'h0, 0, 1);
        expect_a("t3_half_misaligned", 32'h88F0AABB, 1'b1);
        cycle(1, 1, 'h12, 2, 0, 32'h12345678, 0, 1);
        expect_a("t3_word_misaligned", 32'h88F0AABB, 1'b1);
        cycle(1, 0, 'h10, 2, 0, 32'h0, 0, 1);
        expect_a("t3_word_intact", 32'h88F0AABB, 1'b0);

        // 4: words 0..3 hold their index, full-rate dump
        for (int i = 0; i < DW; i++) cycle(1, 1, 4*i, 2, 0, 32'(i), 0, 1);
        cycle(0, 0, 0, 0, 0, 32'h0, 1, 1);
        iters = 0;
        for (int n = 0; n < 40; n++) begin
            idle(1'b1);
            iters++;
            #2;
            if (dq.size() == 0 && !dump_busy) break;
        end
        check("t4_edges_to_idle", iters, 9);
        check("t4_queue_drained", dq.size(), 0);
        check("t4_busy_clear", {31'b0, dump_busy}, 32'h0);

        // 5: backpressure with a second dump_start that must be ignored
        cycle(0, 0, 0, 0, 0, 32'h0, 1, 0);
        for (int n = 0; n < 8; n++) cycle(0, 0, 0, 0, 0, 32'h0, n == 2, 0);
        #2;
        check("t5_valid_held", {31'b0, dump_valid}, 32'h1);
        check("t5_addr_held", 32'(dump_addr), 32'h0);
        check("t5_data_held", dump_data, 32'h0);
        drain_dump("t5", 40);

        // 6: reset while word 2 is presented and port A is loading
        cycle(0, 0, 0, 0, 0, 32'h0, 1, 1);
        found = 1'b0;
        for (int n = 0; n < 20; n++) begin
            cycle(1, 0, 'h8, 2, 0, 32'h0, 0, 1);
            if (dump_valid && dump_addr == WAW'(2)) begin
                found = 1'b1;
                break;
            end
        end
        check("t6_reached_addr2", {31'b0, found}, 32'h1);
        #1;
        rsta = 1'b1;
        in_reset = 1'b1;
        #1;
        check_all_zero("t6_reset");
        ena = 1'b0; dump_start = 1'b0;
        aq.delete(); dq.delete();
        m_busy = 1'b0; m_douta = '0; m_err = 1'b0;
        @(posedge clka);
        #1;
        rsta = 1'b0;
        in_reset = 1'b0;
        cycle(1, 0, 'h8, 2, 0, 32'h0, 0, 1);
        expect_a("t6_word2_kept", 32'h00000002, 1'b0);
        cycle(1, 0, 'h10, 2, 0, 32'h0, 0, 1);
        expect_a("t6_word4_kept", 32'h88F0AABB, 1'b0);

        // Random traffic; stores avoid the dumped words while a dump is in flight
        for (int n = 0; n < 600; n++) begin
            a = int'($urandom_range(0, DEPTH*4 - 1));
            s = int'($urandom_range(0, 3));
            w = ($urandom_range(0, 1) == 1);
            if (w && m_busy && a < DW*4) a = a + DW*4;
            cycle($urandom_range(0, 3) != 0, w, a, s, $urandom_range(0, 1) == 1, $urandom,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
        end
        drain_dump("end", 100);
        repeat (LAT + 1) idle(1'b1);
        @(posedge clka);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
